four_bit_adder: RTL and testbench
=================================

Name: four_bit_adder

Overview:
- Registered unsigned adder: two WIDTH-bit operands plus carry-in; produces a (WIDTH+1)-bit sum whose MSB is the carry-out.
- Datapath built structurally as a ripple chain of full-adder cells; result captured in an output register with one-cycle latency.
- Used as a small arithmetic leaf in datapaths and as a reference block for adder verification.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..16; sum width is WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in; tie to 0 for plain A+B.
- in_valid  input  1  operands and cin valid this cycle.
- s  output  WIDTH+1  registered sum; s[WIDTH] is carry-out.
- out_valid  output  1  s holds the result of an accepted operation.
- ovf  output  1  registered signed overflow, i.e. two's-complement overflow of the low WIDTH bits.

Behaviour:
- Reset: on rst=1, immediately and asynchronously, s=0, out_valid=0, ovf=0. The block holds these values while rst is high.
- Combinational core: the carry chain is c[0]=cin and c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]). The sum bit is sum[i]=a[i]^b[i]^c[i]. The carry-out is c[WIDTH].
- The full sum is {c[WIDTH], sum[WIDTH-1:0]}, which equals a+b+cin exactly with no truncation. The maximum is 2*(2^WIDTH-1)+1, which is 31 for WIDTH=4.
- Signed overflow is c[WIDTH]^c[WIDTH-1].
- Capture: on the rising clk edge with in_valid=1, the block registers s, ovf and sets out_valid=1.
- On a rising edge with in_valid=0, out_valid goes to 0 and s and ovf hold their last values.
- Latency: exactly 1 cycle from operand sample to s. Throughput is one operation per cycle with no back-pressure.
- A new operand each cycle produces back-to-back results, each one cycle after its inputs.
- Reset asserted mid-stream discards any in-flight result. The first valid result after deassertion appears one cycle after the first in_valid edge.
- Inputs that change between edges have no effect. Only values present at the rising edge matter.
- No X propagation requirements beyond standard RTL. Operand values are always interpreted as unsigned for s.

Optional Feature:
- Macro FOUR_BIT_ADDER_LOOKAHEAD_EN.
- When defined, the carry chain is replaced by a carry-lookahead structure. It uses generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i], grouped in 4-bit lookahead blocks with ripple between blocks.
- Outputs must be bit-identical to the ripple version for all inputs, with the same latency, reset values and ports.
- When not defined, the ripple-carry chain described above is used.

Test Plan:
- Reset then idle: assert rst with in_valid=0 → s=0, out_valid=0, ovf=0. Then deassert rst → outputs unchanged.
- Directed sequence with cin=0 and in_valid=1, one operand pair per cycle; check each result one cycle after its inputs:
  - a=0, b=0 → s=0, ovf=0.
  - a=0, b=1 → s=1.
  - a=0, b=15 → s=15, ovf=0.
  - a=15, b=15 → s=30 (5'b11110), ovf=0.
  - a=1, b=15 → s=16 (5'b10000), ovf=0.
- Carry-in and overflow: a=15, b=15, cin=1 → s=31. Then a=7, b=1, cin=0 → s=8, ovf=1. Then a=8, b=8 → s=16, ovf=1.
- Valid handling: apply a=3, b=4 with in_valid=1, then in_valid=0 for 2 cycles with a and b changing → s stays 7. out_valid is 1 for exactly one cycle.
- Async reset mid-stream: while a result is pending, pulse rst between clock edges → s=0 and out_valid=0 immediately, without waiting for a clk edge.
- Exhaustive sweep: all 16×16×2 combinations of a, b and cin, compared one cycle later against a+b+cin. Run with and without FOUR_BIT_ADDER_LOOKAHEAD_EN; both builds must give identical s and ovf.

Source files
------------

// File: rtl/four_bit_adder.sv
// four_bit_adder: registered unsigned adder, s = a + b + cin with one-cycle latency
// Ports: clk, rst (async, active-high), a/b operands, cin carry-in, in_valid qualifier;
//        s (WIDTH+1 bits, MSB is carry-out), out_valid, ovf (signed overflow of low WIDTH bits).
// Build option: define FOUR_BIT_ADDER_LOOKAHEAD_EN for 4-bit carry-lookahead blocks
//               rippling between blocks; the default build uses a plain ripple chain.
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH:0]   s,
  output logic             out_valid,
  output logic             ovf
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] g, p, sum;
  assign g = a & b;
  assign p = a ^ b;
`ifdef FOUR_BIT_ADDER_LOOKAHEAD_EN
  logic gp, pp;
  // Each carry is formed directly from the carry entering its 4-bit block,
  // so blocks only ripple at their boundaries.
  always_comb begin
    c = '0;
    gp = 1'b0;
    pp = 1'b0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      gp = g[i];
      pp = p[i];
      for (int k = i - 1; k >= (i / 4) * 4; k--) begin
        gp = gp | (pp & g[k]);
        pp = pp & p[k];
      end
      c[i+1] = gp | (pp & c[(i/4)*4]);
    end
  end
`else
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++)
      c[i+1] = g[i] | (c[i] & p[i]);
  end
`endif
  assign sum = p ^ c[WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= '0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= {c[WIDTH], sum};
        ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed and exhaustive self-checking bench for four_bit_adder
module tb_four_bit_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [4:0] s;
  logic       out_valid, ovf;
  int total = 0;
  int bad = 0;
  logic [4:0] exp_s;
  logic [3:0] low;
  logic       exp_ovf;

  four_bit_adder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .s(s), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic tv);
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = tv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", s, 0);
    check("rst_vld", out_valid, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_s", s, 0);
    check("idle_vld", out_valid, 0);
    check("idle_ovf", ovf, 0);

    apply(4'd0, 4'd0, 1'b0, 1'b1);
    check("0+0_s", s, 0);
    check("0+0_ovf", ovf, 0);
    check("0+0_vld", out_valid, 1);
    apply(4'd0, 4'd1, 1'b0, 1'b1);
    check("0+1_s", s, 1);
    apply(4'd0, 4'd15, 1'b0, 1'b1);
    check("0+15_s", s, 15);
    check("0+15_ovf", ovf, 0);
    apply(4'd15, 4'd15, 1'b0, 1'b1);
    check("15+15_s", s, 30);
    check("15+15_ovf", ovf, 0);
    apply(4'd1, 4'd15, 1'b0, 1'b1);
    check("1+15_s", s, 16);
    check("1+15_ovf", ovf, 0);
    apply(4'd15, 4'd15, 1'b1, 1'b1);
    check("15+15+1_s", s, 31);
    check("15+15+1_ovf", ovf, 0);
    apply(4'd7, 4'd1, 1'b0, 1'b1);
    check("7+1_s", s, 8);
    check("7+1_ovf", ovf, 1);
    apply(4'd8, 4'd8, 1'b0, 1'b1);
    check("8+8_s", s, 16);
    check("8+8_ovf", ovf, 1);

    apply(4'd3, 4'd4, 1'b0, 1'b1);
    check("3+4_s", s, 7);
    check("3+4_vld", out_valid, 1);
    apply(4'd9, 4'd9, 1'b0, 1'b0);
    check("hold1_s", s, 7);
    check("hold1_vld", out_valid, 0);
    check("hold1_ovf", ovf, 0);
    apply(4'd1, 4'd2, 1'b1, 1'b0);
    check("hold2_s", s, 7);
    check("hold2_vld", out_valid, 0);

    apply(4'd5, 4'd6, 1'b0, 1'b1);
    check("5+6_s", s, 11);
    check("5+6_vld", out_valid, 1);
    @(negedge clk);
    a = 4'd2;
    b = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_s", s, 0);
    check("async_rst_vld", out_valid, 0);
    check("async_rst_ovf", ovf, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s", s, 4);
    check("post_rst_vld", out_valid, 1);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          apply(4'(i), 4'(j), 1'(k), 1'b1);
          exp_s = 5'(i + j + k);
          low = exp_s[3:0];
          exp_ovf = (a[3] == b[3]) && (low[3] != a[3]);
          check($sformatf("sweep_s_%0d_%0d_%0d", i, j, k), s, exp_s);
          check($sformatf("sweep_ovf_%0d_%0d_%0d", i, j, k), ovf, exp_ovf);
        end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
